// File: rtl/bfly_pkg.sv
// rtl/bfly_pkg.sv - shared types for the butterfly pair buffer
// Purpose: FSM state encoding and the complex sample word used by the pair buffer.
// Ports: none (package).
package bfly_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SUM  = 2'd1,
        DIFF = 2'd2
    } state_t;

    // Default sample width of the butterfly datapath.
    localparam int CPLX_W = 12;

    // Packed complex sample; re occupies the upper half of the memory word.
    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/bfly_pair_mem.sv
// rtl/bfly_pair_mem.sv - half-frame sample store with registered read
// Purpose: one synchronous write port and one registered read port holding {re, im}.
// Ports:
//   clk      - clock
//   wr_en    - write wr_data to wr_addr on the rising edge
//   wr_addr  - write address
//   wr_data  - packed {re, im} word
//   rd_en    - capture mem[rd_addr] into the read register
//   rd_addr  - read address
//   rd_data  - registered read data (holds when rd_en=0)
module bfly_pair_mem #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [2*WIDTH-1:0]   wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*WIDTH-1:0]   rd_data
);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [2*WIDTH-1:0] rd_data_q;
    logic [2*WIDTH-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bfly_pair_buf.sv
// rtl/bfly_pair_buf.sv - input pair buffer feeding the radix-2 butterfly
// Purpose: collects 2*NUM_PAIR samples and presents (x[k], x[k+NUM_PAIR]) pairs
//          once for the SUM pass and once for the DIFF pass.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid/in_ready        - input handshake; transfer = in_valid && in_ready
//   in_re/in_im              - input sample
//   out_valid                - aligned pair present (bfly_valid)
//   out_sum                  - 1 = SUM pass pair, 0 = DIFF pass pair
//   out_shift_re/out_shift_im- x[k]
//   out_din_re/out_din_im    - x[k+NUM_PAIR]
//   frame_done               - pulse with the last DIFF pair
module bfly_pair_buf
    import bfly_pkg::*;
#(
    parameter int WIDTH    = CPLX_W,
    parameter int NUM_PAIR = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    output logic                    out_sum,
    output logic signed [WIDTH-1:0] out_shift_re,
    output logic signed [WIDTH-1:0] out_shift_im,
    output logic signed [WIDTH-1:0] out_din_re,
    output logic signed [WIDTH-1:0] out_din_im,
    output logic                    frame_done
);

    localparam int            CW   = $clog2(NUM_PAIR);
    localparam logic [CW-1:0] LAST = CW'(NUM_PAIR - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;

    logic               accept;
    logic               a_we, b_we, a_re, b_re;
    logic [2*WIDTH-1:0] in_word;
    logic [2*WIDTH-1:0] a_rd, b_rd;

    logic               out_valid_q, out_valid_d;
    logic               out_sum_q, out_sum_d;
    logic               frame_done_q, frame_done_d;
    logic [2*WIDTH-1:0] samp_q, samp_d;

    logic [2*WIDTH-1:0] shift_word, din_word;

    assign in_word = {in_re, in_im};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: count advances on every accept in FILL/SUM and every
    // cycle in DIFF; NUM_PAIR is a power of two so the increment wraps itself.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (accept || state_q == DIFF) begin
            count_d = count_q + CW'(1);
            if (count_q == LAST) begin
                case (state_q)
                    FILL:    state_d = SUM;
                    SUM:     state_d = DIFF;
                    default: state_d = FILL;
                endcase
            end
        end
    end

    // Output logic
    always_comb begin
        in_ready     = (state_q != DIFF);
        accept       = in_valid && in_ready;
        a_we         = accept && (state_q == FILL);
        b_we         = accept && (state_q == SUM);
        a_re         = (accept && (state_q == SUM)) || (state_q == DIFF);
        b_re         = (state_q == DIFF);
        out_valid_d  = a_re;
        out_sum_d    = b_we;
        frame_done_d = (state_q == DIFF) && (count_q == LAST);
        // Only consumed when out_sum_q is set, which implies this was a SUM accept.
        samp_d       = in_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_sum_q    <= 1'b0;
            frame_done_q <= 1'b0;
            samp_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            frame_done_q <= frame_done_d;
            samp_q       <= samp_d;
        end
    end

    bfly_pair_mem #(
        .WIDTH (WIDTH),
        .DEPTH (NUM_PAIR)
    ) u_mem_a (
        .clk     (clk),
        .wr_en   (a_we),
        .wr_addr (count_q),
        .wr_data (in_word),
        .rd_en   (a_re),
        .rd_addr (count_q),
        .rd_data (a_rd)
    );

    bfly_pair_mem #(
        .WIDTH (WIDTH),
        .DEPTH (NUM_PAIR)
    ) u_mem_b (
        .clk     (clk),
        .wr_en   (b_we),
        .wr_addr (count_q),
        .wr_data (in_word),
        .rd_en   (b_re),
        .rd_addr (count_q),
        .rd_data (b_rd)
    );

    // Idle cycles present zero data, matching the butterfly's idle zeroing;
    // gating on out_valid_q also clears the outputs immediately on reset.
    always_comb begin
        shift_word = '0;
        din_word   = '0;
        if (out_valid_q) begin
            shift_word = a_rd;
            din_word   = out_sum_q ? samp_q : b_rd;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign frame_done   = frame_done_q;
    assign out_shift_re = shift_word[2*WIDTH-1:WIDTH];
    assign out_shift_im = shift_word[WIDTH-1:0];
    assign out_din_re   = din_word[2*WIDTH-1:WIDTH];
    assign out_din_im   = din_word[WIDTH-1:0];

endmodule

// File: tb/tb_bfly_pair_buf.sv
// tb/tb_bfly_pair_buf.sv - scoreboard bench for bfly_pair_buf
module tb_bfly_pair_buf;
    import bfly_pkg::*;

    localparam int W = CPLX_W;
    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_re = '0;
    logic signed [W-1:0] in_im = '0;
    logic                out_valid, out_sum, frame_done;
    logic signed [W-1:0] out_shift_re, out_shift_im, out_din_re, out_din_im;

    bfly_pair_buf #(.WIDTH(W), .NUM_PAIR(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_re        (in_re),
        .in_im        (in_im),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_shift_re (out_shift_re),
        .out_shift_im (out_shift_im),
        .out_din_re   (out_din_re),
        .out_din_im   (out_din_im),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        bit    sm;
        cplx_t sh;
        cplx_t dn;
        bit    fd;
    } exp_t;

    exp_t  expq[$];
    cplx_t frame[$];
    int    diff_left = 0;
    int    total = 0;
    int    bad = 0;
    int    npairs = 0;
    int    fd_cyc[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic cplx_t mk(input int re, input int im);
        cplx_t s;
        s.re = W'(re);
        s.im = W'(im);
        return s;
    endfunction

    function automatic cplx_t rnd();
        cplx_t s;
        s.re = ($urandom_range(0, 3) == 0) ? W'(2047) : W'($urandom);
        s.im = ($urandom_range(0, 3) == 0) ? W'(-2048) : W'($urandom);
        return s;
    endfunction

    // One cycle of stimulus plus the reference model: a frame is a list of
    // accepted samples; the second half produces SUM pairs as it arrives, and
    // a full frame is followed by N cycles of DIFF pairs with no input taken.
    task automatic drive_cycle(input bit v, input cplx_t s, output bit acc);
        bit ready_m;
        @(negedge clk);
        in_valid = v;
        in_re    = s.re;
        in_im    = s.im;
        ready_m  = (diff_left == 0);
        chk("in_ready", 64'(in_ready), 64'(ready_m));
        acc = v && ready_m;
        if (diff_left > 0) begin
            int k;
            k = N - diff_left;
            expq.push_back('{cyc + 1, 1'b0, frame[k], frame[k + N], (k == N - 1)});
            diff_left--;
            if (diff_left == 0) frame.delete();
        end else if (acc) begin
            frame.push_back(s);
            if (frame.size() > N)
                expq.push_back('{cyc + 1, 1'b1, frame[frame.size() - 1 - N], s, 1'b0});
            if (frame.size() == 2 * N) diff_left = N;
        end
    endtask

    task automatic offer(input cplx_t s);
        bit acc;
        for (int t = 0; t < 64; t++) begin
            drive_cycle(1'b1, s, acc);
            if (acc) return;
        end
        chk("offer_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int t = 0; t < n; t++) drive_cycle(1'b0, mk(0, 0), acc);
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (diff_left == 0 && expq.size() == 0) break;
            idle(1);
        end
        idle(1);
        chk("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_sum"}, 64'(out_sum), 64'd0);
        chk({nm, "_fd"}, 64'(frame_done), 64'd0);
        chk({nm, "_data"}, 64'({out_shift_re, out_shift_im, out_din_re, out_din_im}), 64'd0);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        in_valid = 1'b0;
        frame.delete();
        expq.delete();
        diff_left = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("ready_after_rst", 64'(in_ready), 64'd1);
    endtask

    // Monitor: pops the expected pair whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                npairs++;
                if (frame_done) fd_cyc.push_back(cyc);
                if (expq.size() == 0) begin
                    chk("unexpected_pair", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("pair_cycle", 64'(cyc), 64'(e.due));
                    chk("out_sum", 64'(out_sum), 64'(e.sm));
                    chk("shift", 64'({out_shift_re, out_shift_im}), 64'(e.sh));
                    chk("din", 64'({out_din_re, out_din_im}), 64'(e.dn));
                    chk("frame_done", 64'(frame_done), 64'(e.fd));
                end
            end else begin
                chk("idle_zero", 64'({out_sum, frame_done, out_shift_re, out_shift_im,
                                      out_din_re, out_din_im}), 64'd0);
                if (expq.size() > 0 && expq[0].due <= cyc) begin
                    chk("missing_pair", 64'd0, 64'd1);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Basic frame, then a sample held through DIFF (backpressure).
        for (int i = 1; i <= 2 * N; i++) offer(mk(i, -i));
        offer(mk(100, -100));
        // Rest of that frame with alternating gaps.
        for (int i = 0; i < 2 * N - 1; i++) begin
            offer(rnd());
            idle(1);
        end

        // Extremes in both halves.
        for (int i = 0; i < 2 * N; i++)
            offer((i % 2 == 0) ? mk(2047, -2048) : mk(-2048, 2047));
        drain();

        // Reset after two SUM accepts, then the basic frame again.
        for (int i = 0; i < N + 2; i++) offer(rnd());
        reset_mid();
        for (int i = 1; i <= 2 * N; i++) offer(mk(i, -i));
        drain();

        // Three back-to-back frames.
        fd_cyc.delete();
        npairs = 0;
        for (int i = 0; i < 6 * N; i++) offer(rnd());
        drain();
        chk("b2b_pairs", 64'(npairs), 64'(6 * N));
        chk("b2b_fd_count", 64'(fd_cyc.size()), 64'd3);
        if (fd_cyc.size() == 3) begin
            chk("b2b_fd_gap1", 64'(fd_cyc[1] - fd_cyc[0]), 64'(3 * N));
            chk("b2b_fd_gap2", 64'(fd_cyc[2] - fd_cyc[1]), 64'(3 * N));
        end

        // Random soak with random gaps.
        for (int i = 0; i < 8 * N; i++) begin
            offer(rnd());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bfly_pair_buf.md
Name: bfly_pair_buf

Overview:
- Input-side pair buffer for the radix-2 butterfly stage.
- Collects a frame of 2*NUM_PAIR complex samples.
- Presents aligned pairs (x[k], x[k+NUM_PAIR]) to the butterfly twice per frame: once for the SUM pass and once for the DIFF pass.
- Sits directly upstream of the butterfly. It drives the butterfly's shift_data, din and bfly_valid inputs.

Parameters:
- WIDTH, 12, signed bit width of each real/imag sample.
- NUM_PAIR, 16, pairs per frame (legal values 2, 4, 8, 16; half-frame length).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample offered on in_re/in_im this cycle.
- in_ready  output  1  block accepts a sample this cycle; transfer = in_valid && in_ready.
- in_re  input  WIDTH  signed real part of input sample.
- in_im  input  WIDTH  signed imaginary part of input sample.
- out_valid  output  1  aligned pair present on out_* (drives bfly_valid).
- out_sum  output  1  1 = SUM pass pair, 0 = DIFF pass pair; meaningful only with out_valid.
- out_shift_re  output  WIDTH  x[k] real part (drives shift_data_re).
- out_shift_im  output  WIDTH  x[k] imaginary part (drives shift_data_im).
- out_din_re  output  WIDTH  x[k+NUM_PAIR] real part (drives din_re).
- out_din_im  output  WIDTH  x[k+NUM_PAIR] imaginary part (drives din_im).
- frame_done  output  1  one-cycle pulse coincident with the last DIFF pair.

Behaviour:
- Reset (rst=1, async): state=FILL, count=0.
  - out_valid=0, out_sum=0, frame_done=0.
  - All out_* data=0.
  - in_ready=1 once rst deasserts.
  - Memory contents are don't-care.
- Reset mid-frame: the partial frame is discarded. The next accepted sample is x[0].
- count: $clog2(NUM_PAIR) bits. Wraps NUM_PAIR-1 -> 0 and the state advances on the same edge.
- FSM states: FILL, SUM, DIFF.
- FILL:
  - in_ready=1.
  - Each accepted sample is written to mem_a[count], then count++.
  - out_valid=0 throughout.
  - On the accept with count==NUM_PAIR-1 -> SUM.
- SUM:
  - in_ready=1.
  - Each accepted sample is written to mem_b[count]. mem_a[count] is read; count++.
  - Next cycle: out_valid=1, out_sum=1, out_shift=mem_a[k], out_din=accepted sample.
  - The pair is output-registered, so latency is 1 cycle from accept.
  - On the accept with count==NUM_PAIR-1 -> DIFF.
- DIFF:
  - in_ready=0. in_valid is ignored and no sample is consumed.
  - Every cycle, mem_a[count] and mem_b[count] are read; count++. No stalls.
  - Next cycle: out_valid=1, out_sum=0, out_shift=mem_a[k], out_din=mem_b[k].
  - At count==NUM_PAIR-1 -> FILL.
  - DIFF pairs therefore appear on NUM_PAIR consecutive cycles, starting 1 cycle after DIFF is entered.
- frame_done=1 on the cycle carrying the DIFF pair with k=NUM_PAIR-1. It is 0 otherwise.
- Input gaps in FILL/SUM: count holds. The cycle after a non-accept has out_valid=0 and out data forced to 0 (same as the butterfly's idle zeroing).
- Transition overlap:
  - The first FILL accept of the next frame can occur on the same cycle the last DIFF pair is output (in_ready=1 as soon as state==FILL).
  - Back-to-back frames therefore sustain 2N input samples per 3N cycles.
- No arithmetic on data. Samples are passed bit-exact with WIDTH unchanged. Widening to WIDTH+1 happens in the butterfly.
- in_ready is combinational from state only, with no dependence on in_valid.

Decomposition:
- Package bfly_pkg:
  - state_t enum {FILL, SUM, DIFF} (logic [1:0]).
  - Shared complex sample struct typedef cplx_t {re, im} for the packed memory word.
- Sub-module bfly_pair_mem #(WIDTH, DEPTH):
  - One synchronous write port and one registered read port, storing {re, im}.
  - Instantiated twice: mem_a and mem_b.
  - Read-during-write to different addresses only; the same address is never read and written in one cycle by construction.

Test Plan:
- Basic frame, NUM_PAIR=4, continuous in_valid, in_re=1..8, in_im=-1..-8:
  - SUM pairs (shift,din) re = (1,5),(2,6),(3,7),(4,8), out_sum=1, on cycles 5-8 after the first accept.
  - Then DIFF pairs with the same values, out_sum=0.
  - frame_done with pair (4,8).
- Backpressure: assert in_valid during DIFF -> in_ready=0, no sample consumed. The held sample is accepted as x[0] of the next frame on the first FILL cycle.
- Input gaps: in_valid toggling 1,0,1,0 through SUM -> out_valid pattern 1,0,1,0 delayed 1 cycle; zeros on gap cycles; pairs still correct.
- Extremes, WIDTH=12: samples 2047 and -2048 in both halves -> passed bit-exact on out_shift/out_din with no sign corruption.
- Reset mid-SUM after 2 pairs -> all outputs 0 immediately (async). A fresh frame afterwards reproduces the basic-frame results exactly.
- Back-to-back 3 frames, NUM_PAIR=16 -> 96 valid pairs total, 3 frame_done pulses spaced exactly 48 cycles apart.
